// File: rtl/store_rmw_unit.sv
// -----------------------------------------------------------------------------
// store_rmw_unit
//
// Narrowing store path between the MEM-stage store request and a word-addressed
// data memory. Only the low-order 1, 2 or 4 bytes of the register value are
// stored. Byte and half stores become a read-modify-write of the containing
// word. Word stores go straight to a write.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous, active-high reset
//   req_valid_i  store request valid
//   req_ready_o  unit can accept a request (IDLE only)
//   addr_i       byte address of the store
//   data_i       register value; only the low bytes are stored
//   size_i       00 byte, 01 half, 10 word, 11 illegal
//   mem_addr_o   word address of the access (byte address with [1:0] cleared)
//   mem_rd_o     read request, held until mem_ack_i
//   mem_wr_o     write request, held until mem_ack_i
//   mem_wdata_o  merged write word
//   mem_rdata_i  read data, valid together with mem_ack_i during a read
//   mem_ack_i    memory completes the current read or write this cycle
//   done_o       one-cycle pulse: store completed
//   err_o        one-cycle pulse: misaligned, illegal size or timeout
//
// Parameters
//   ADDR_W   byte-address width
//   TIMEOUT  cycles a read or write may wait for mem_ack_i before the access
//            is abandoned with err_o; 0 disables the timeout
//
// Every output is a flop, so mem_ack_i never reaches an output combinationally.
// -----------------------------------------------------------------------------
module store_rmw_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        size_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              done_o,
  output logic              err_o
);

  // Size encodings of size_i.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The wait counter only has to reach TIMEOUT; it is kept one bit wide when
  // the timeout is disabled or trivially small.
  localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // A request is illegal when the size code is reserved or the address is not
  // naturally aligned for the requested size. Bytes are always aligned.
  function automatic logic size_illegal(input logic [1:0] size,
                                        input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane merge: the addressed byte or half-word lane takes the
  // low bits of the store data; all other lanes keep the memory contents.
  // Only byte and half sizes ever reach the merge; any other size leaves the
  // word unchanged.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [15:0] st_data,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] merged;
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'b00:   merged[7:0]   = st_data[7:0];
          2'b01:   merged[15:8]  = st_data[7:0];
          2'b10:   merged[23:16] = st_data[7:0];
          2'b11:   merged[31:24] = st_data[7:0];
          default: merged        = old_word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merged[31:16] = st_data;
        end else begin
          merged[15:0]  = st_data;
        end
      end
      default: merged = old_word;
    endcase
    return merged;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_r;
  logic [1:0]       lane_r;   // addr[1:0] of the accepted store
  logic [1:0]       size_r;
  logic [15:0]      data_r;   // only the bits a byte/half merge can use
  logic [CNT_W-1:0] cnt_r;    // cycles spent waiting for mem_ack_i
  logic             wait_expired_s;

  // The current READ/WRITE access has waited its full budget without an ack.
  assign wait_expired_s = TIMEOUT_EN && (cnt_r == TIMEOUT_C);

  // Store sequencer: state, latched request, wait counter and all outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      lane_r      <= 2'b00;
      size_r      <= 2'b00;
      data_r      <= 16'h0000;
      cnt_r       <= CNT_ZERO;
      req_ready_o <= 1'b1;
      mem_addr_o  <= '0;
      mem_rd_o    <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_wdata_o <= 32'h0000_0000;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            lane_r      <= addr_i[1:0];
            size_r      <= size_i;
            data_r      <= data_i[15:0];
            cnt_r       <= CNT_ZERO;
            req_ready_o <= 1'b0;
            if (size_illegal(size_i, addr_i[1:0])) begin
              // Rejected before any memory access is started.
              err_o   <= 1'b1;
              state_r <= ST_ERR;
            end else if (size_i == SZ_WORD) begin
              mem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_wdata_o <= data_i;
              mem_wr_o    <= 1'b1;
              state_r     <= ST_WRITE;
            end else begin
              mem_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
              mem_rd_o   <= 1'b1;
              state_r    <= ST_READ;
            end
          end else begin
            req_ready_o <= 1'b1;
          end
        end

        ST_READ: begin
          if (mem_ack_i) begin
            mem_wdata_o <= merge_word(mem_rdata_i, data_r, lane_r, size_r);
            mem_rd_o    <= 1'b0;
            mem_wr_o    <= 1'b1;
            cnt_r       <= CNT_ZERO;
            state_r     <= ST_WRITE;
          end else if (wait_expired_s) begin
            // Read never answered: abandon without issuing the write.
            mem_rd_o <= 1'b0;
            err_o    <= 1'b1;
            state_r  <= ST_ERR;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_WRITE: begin
          if (mem_ack_i) begin
            mem_wr_o <= 1'b0;
            done_o   <= 1'b1;
            state_r  <= ST_DONE;
          end else if (wait_expired_s) begin
            mem_wr_o <= 1'b0;
            err_o    <= 1'b1;
            state_r  <= ST_ERR;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_DONE: begin
          done_o      <= 1'b0;
          req_ready_o <= 1'b1;
          state_r     <= ST_IDLE;
        end

        ST_ERR: begin
          err_o       <= 1'b0;
          req_ready_o <= 1'b1;
          state_r     <= ST_IDLE;
        end

        default: begin
          // Unreachable encodings recover to a quiet IDLE.
          mem_rd_o    <= 1'b0;
          mem_wr_o    <= 1'b0;
          done_o      <= 1'b0;
          err_o       <= 1'b0;
          req_ready_o <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Sub-word store path for the data-memory side of the CPU/cache simulator: it accepts a 32-bit register value with a byte/half/word size and writes only the low-order 1, 2 or 4 bytes into a word-addressed memory. Byte and half stores are done as read-modify-write; word stores write directly. It is the narrowing counterpart of the load-side sign/zero extension. It sits between the MEM stage store request and the cache/data-memory port.

## Interface
- ADDR_W, 32, byte-address width
- TIMEOUT, 255, max cycles waiting on mem_ack_i per access before error; 0 disables timeout
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  store request valid
- req_ready_o  out  1  unit can accept a request (IDLE only)
- addr_i  in  ADDR_W  byte address of store
- data_i  in  32  register value; low bytes are stored
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_addr_o  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_rd_o  out  1  memory read request, held until ack
- mem_wr_o  out  1  memory write request, held until ack
- mem_wdata_o  out  32  merged write word
- mem_rdata_i  in  32  read data, valid with mem_ack_i during read
- mem_ack_i  in  1  memory completes current read or write this cycle
- done_o  out  1  one-cycle pulse: store completed
- err_o  out  1  one-cycle pulse: misaligned, illegal size, or timeout

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- Reset: state IDLE; req_ready_o=1; mem_rd_o, mem_wr_o, done_o, err_o = 0; mem_addr_o, mem_wdata_o, internal registers = 0; timeout counter = 0.
- IDLE: req_ready_o=1. On req_valid_i, latch addr, data, size.
  - Illegal: size 11, half with addr[0]=1, word with addr[1:0]!=0 -> ERR, no memory access.
  - Word -> WRITE with mem_wdata_o=data_i.
  - Byte/half -> READ.
- READ: mem_rd_o=1. On mem_ack_i, merge into mem_wdata_o and go to WRITE.
  - Lanes are little-endian.
  - Byte: lane addr[1:0] gets data[7:0].
  - Half: lane pair addr[1] (0 -> bits 15:0, 1 -> bits 31:16) gets data[15:0].
  - Other lanes come from mem_rdata_i unchanged. data bits above the stored width are ignored.
- WRITE: mem_wr_o=1, mem_wdata_o stable. On mem_ack_i -> DONE.
- DONE: done_o=1 for one cycle -> IDLE. ERR: err_o=1 for one cycle -> IDLE.
- mem_rd_o and mem_wr_o are never both 1. mem_addr_o is constant from READ/WRITE entry until return to IDLE.
- Timeout: counter clears on entry to READ/WRITE and increments each cycle without ack. If TIMEOUT!=0 and counter reaches TIMEOUT with no ack -> ERR; no write is issued after a read timeout.
- Reset mid-operation (any state) returns immediately to the reset values; the partial store is abandoned and never written.

## Timing
- Request accepted on the rising edge where req_valid_i & req_ready_o; req_ready_o=0 from the next cycle until back in IDLE.
- All outputs are registered/state-decoded; no combinational path from mem_ack_i to any output.
- Word store, ack in first WRITE cycle: accept at edge 0, WRITE during cycle 1, done_o in cycle 2, req_ready_o=1 in cycle 3. Minimum 3 cycles accept-to-ready.
- Byte/half, single-cycle acks: READ cycle 1, WRITE cycle 2, done_o cycle 3, ready cycle 4.
- Each cycle of ack delay adds one cycle. mem_ack_i seen in IDLE/DONE/ERR is ignored.
- Illegal request: err_o in cycle 1, ready in cycle 2.
- Timeout with TIMEOUT=N: err_o asserted N+1 cycles after entering the waiting state.

## Test plan
- Byte store addr=0x1002, data=0xDEADBEEF, mem_rdata_i=0x11223344 -> one read at 0x1000, write 0x11EF3344, one done_o pulse, 4 cycles accept-to-ready.
- Half store addr=0x0006, data=0x0000ABCD, rdata=0xFFFFFFFF, ack delayed 3 cycles on read -> write 0xABCDFFFF; mem_rd_o held through the delay.
- Word store addr=0x0010, data=0xCAFEF00D -> no read, write 0xCAFEF00D, done_o in cycle 2.
- Half at addr=0x0003, word at addr=0x0002, size=11 -> err_o pulse each, mem_rd_o/mem_wr_o never asserted.
- TIMEOUT=4, read never acked -> err_o 5 cycles after READ entry, mem_wr_o never asserted; a later legal store completes normally.
- rst_i asserted during WRITE -> mem_wr_o and every other output drop to reset values asynchronously; req_ready_o=1 after release.
